// File: rtl/mmio_controller_if.sv
// ----------------------------------------------------------------------------
// mmio_controller_if
// Bundles the processor data-memory port and the data-RAM port that the MMIO
// controller sits between.
//   master : processor/RAM side (drives address, write data, write enable and
//            the raw RAM read data)
//   slave  : mmio_controller (returns read data to the processor and the
//            filtered RAM write enable)
// ----------------------------------------------------------------------------
interface mmio_controller_if;
    logic [31:0] address_dmem;  // processor word address
    logic [31:0] data;          // processor write data
    logic        wren;          // processor write enable
    logic [31:0] q_ram;         // read data from data RAM
    logic [31:0] q_dmem;        // read data to processor
    logic        ram_wren;      // write enable to data RAM

    modport master (
        output address_dmem, data, wren, q_ram,
        input  q_dmem, ram_wren
    );

    modport slave (
        input  address_dmem, data, wren, q_ram,
        output q_dmem, ram_wren
    );
endinterface

// File: rtl/mmio_controller.sv
// ----------------------------------------------------------------------------
// mmio_controller
// Memory-mapped I/O controller between the processor data port and data RAM.
// A four-word window at IO_BASE holds:
//   +0 SW     (RO)    debounced switches, zero-extended
//   +1 LED    (RW)    LED register
//   +2 TIMER  (RW)    32-bit countdown timer
//   +3 STATUS (R/W1C) bit0 timer_done, bit1 sw_changed
// Writes inside the window never reach RAM; reads inside the window return
// the register value instead of RAM data, with no added latency.
// Ports:
//   clock      system clock, all state on posedge
//   reset      asynchronous active-low reset
//   bus        processor/RAM port bundle (slave side)
//   sw_in      raw asynchronous switch pins
//   led_out    LED drive
//   timer_irq  copy of STATUS bit0
// ----------------------------------------------------------------------------
module mmio_controller #(
    parameter logic [31:0] IO_BASE         = 32'd4096,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned LED_WIDTH       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_controller_if.slave     bus,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 timer_irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      IO_LAST  = IO_BASE + 32'd3;

    localparam logic [1:0] OFF_SW     = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       io_hit;
    logic [1:0] io_off;
    logic       wr_led;
    logic       wr_timer;
    logic       wr_status;

    assign io_hit    = (bus.address_dmem >= IO_BASE) && (bus.address_dmem <= IO_LAST);
    // Only the low two bits of (address - IO_BASE) matter inside the window,
    // and they equal the difference of the low two bits (mod 4).
    assign io_off    = bus.address_dmem[1:0] - IO_BASE[1:0];
    assign wr_led    = bus.wren && io_hit && (io_off == OFF_LED);
    assign wr_timer  = bus.wren && io_hit && (io_off == OFF_TIMER);
    assign wr_status = bus.wren && io_hit && (io_off == OFF_STATUS);

    assign bus.ram_wren = bus.wren && !io_hit;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0]  sync1_q,     sync1_d;
    logic [SW_WIDTH-1:0]  sync2_q,     sync2_d;
    logic [SW_WIDTH-1:0]  sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0]     deb_cnt_q,   deb_cnt_d;
    logic [LED_WIDTH-1:0] led_q,       led_d;
    logic [31:0]          timer_q,     timer_d;
    logic [1:0]           status_q,    status_d;

    logic sw_accept;
    logic timer_expire;

    always_comb begin
        // Two-flop synchroniser; sync2_q is the only stage the debouncer sees.
        sync1_d = sw_in;
        sync2_d = sync1_q;

        // Whole-vector debounce: the counter only runs while the synchronised
        // vector differs from the accepted one, and any return to the accepted
        // value restarts it. Acceptance happens on the cycle after the counter
        // has reached its last value, giving DEBOUNCE_CYCLES differing samples.
        sw_stable_d = sw_stable_q;
        deb_cnt_d   = '0;
        sw_accept   = 1'b0;
        if (sync2_q != sw_stable_q) begin
            if (deb_cnt_q == CNT_LAST) begin
                sw_stable_d = sync2_q;
                sw_accept   = 1'b1;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        led_d = wr_led ? bus.data[LED_WIDTH-1:0] : led_q;

        // A bus write wins over the decrement, so writing 0 while the count
        // is 1 stops the timer without reporting an expiry.
        timer_expire = 1'b0;
        if (wr_timer) begin
            timer_d = bus.data;
        end else if (timer_q != 32'd0) begin
            timer_d      = timer_q - 32'd1;
            timer_expire = (timer_q == 32'd1);
        end else begin
            timer_d = timer_q;
        end

        // W1C first, then sets, so a same-cycle set survives the clear.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~bus.data[1:0];
        end
        if (timer_expire) begin
            status_d[0] = 1'b1;
        end
        if (sw_accept) begin
            status_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sw_stable_q <= '0;
            deb_cnt_q   <= '0;
            led_q       <= '0;
            timer_q     <= '0;
            status_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sw_stable_q <= sw_stable_d;
            deb_cnt_q   <= deb_cnt_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path (combinational, reads have no side effects)
    // ------------------------------------------------------------------
    logic [31:0] io_rdata;

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_SW:     io_rdata[SW_WIDTH-1:0]  = sw_stable_q;
            OFF_LED:    io_rdata[LED_WIDTH-1:0] = led_q;
            OFF_TIMER:  io_rdata                = timer_q;
            OFF_STATUS: io_rdata[1:0]           = status_q;
            default:    io_rdata                = '0;
        endcase
    end

    assign bus.q_dmem = io_hit ? io_rdata : bus.q_ram;

    assign led_out   = led_q;
    assign timer_irq = status_q[0];

endmodule
